// File: rtl/ov_flag_reg.sv
// Architectural overflow-flag register with a normal commit path and a multi-cycle OR-accumulate path.
// Optional saturating commit-of-one event counter is enabled by defining OV_EVENT_COUNT_EN.
module ov_flag_reg #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             OvInputMuxData,
  input  logic             OvWrEn,
  input  logic             AccStart,
  input  logic             AccEnd,
  input  logic             OvClr,
  input  logic             Stall,
  output logic             OvFlag,
  output logic             OvPrev,
  output logic             AccBusy,
  output logic [CNT_W-1:0] OvEventCnt,
  output logic             OvCntSat
);

  // One-hot encoding leaves two illegal codes, both of which fall back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_ACCUM = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   acc_q, acc_d;
  logic   flag_q, flag_d;
  logic   prev_q, prev_d;
  logic   busy_q;
  logic   commit;
  logic   commit_val;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_d    = state_q;
    acc_d      = acc_q;
    flag_d     = flag_q;
    prev_d     = prev_q;
    commit     = 1'b0;
    commit_val = 1'b0;

    if (OvClr) begin
      state_d = ST_IDLE;
      acc_d   = 1'b0;
      flag_d  = 1'b0;
      prev_d  = 1'b0;
    end else if (!Stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (AccStart) begin
            state_d = ST_ACCUM;
            acc_d   = OvWrEn & OvInputMuxData;
          end else if (OvWrEn) begin
            commit     = 1'b1;
            commit_val = OvInputMuxData;
          end
        end
        ST_ACCUM: begin
          if (AccEnd) begin
            commit     = 1'b1;
            commit_val = acc_q | (OvWrEn & OvInputMuxData);
            acc_d      = 1'b0;
            state_d    = ST_IDLE;
          end else if (OvWrEn) begin
            acc_d = acc_q | OvInputMuxData;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = 1'b0;
        end
      endcase

      if (commit) begin
        flag_d = commit_val;
        prev_d = flag_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values
    // regardless of the order the simulator evaluates the blocks.
    if (Reset) begin
      state_q <= ST_IDLE;
      acc_q   <= 1'b0;
      flag_q  <= 1'b0;
      prev_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      prev_q  <= prev_d;
      busy_q  <= (state_d == ST_ACCUM);
    end
  end

  assign OvFlag  = flag_q;
  assign OvPrev  = prev_q;
  assign AccBusy = busy_q;

`ifdef OV_EVENT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             cnt_inc;

  // commit is already suppressed under OvClr and Stall, so the counter needs no extra gating.
  assign cnt_inc = commit & commit_val;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == (CNT_MAX - CNT_W'(1))) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign OvEventCnt = cnt_q;
  assign OvCntSat   = sat_q;
`else
  assign OvEventCnt = '0;
  assign OvCntSat   = 1'b0;
`endif

endmodule
